// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite AW/W/B/AR/R channel bundle between a bus master and a register slave.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register bank slave; top register is a read-only ID, all registers exported on reg_out.
// Latency: write response and read data one cycle after the completing handshake.
// Backpressure: one outstanding write and one outstanding read; READYs drop until B/R is taken.
module axi_lite_reg_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'hA71E_0001
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    axi_lite_reg_slave_if.slave            s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int              IDX_W       = $clog2(NUM_REGS);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [IDX_W-1:0] ID_IDX     = IDX_W'(NUM_REGS - 1);

    // Any address bit above the register index makes the access out of range.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (2 + IDX_W)) == '0;
    endfunction

    logic                  rst_done;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    assign s_axi.AWREADY = rst_done & ~aw_held & ~s_axi.BVALID;
    assign s_axi.WREADY  = rst_done & ~w_held  & ~s_axi.BVALID;
    assign s_axi.ARREADY = rst_done & ~s_axi.RVALID;

    assign aw_hs = s_axi.AWVALID & s_axi.AWREADY;
    assign w_hs  = s_axi.WVALID  & s_axi.WREADY;
    assign ar_hs = s_axi.ARVALID & s_axi.ARREADY;

    // A held half takes priority over the bus so the commit uses what was accepted.
    always_comb begin
        wr_addr = aw_held ? aw_addr_q : s_axi.AWADDR;
        wr_data = w_held  ? w_data_q  : s_axi.WDATA;
        wr_idx  = wr_addr[2 +: IDX_W];
        commit  = (aw_held | aw_hs) & (w_held | w_hs);
        wr_ok   = addr_in_range(wr_addr) && (wr_idx != ID_IDX);
    end

    always_comb begin
        rd_idx  = s_axi.ARADDR[2 +: IDX_W];
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (addr_in_range(s_axi.ARADDR)) begin
            rd_resp = RESP_OKAY;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_data = regs[i];
                end
            end
            if (rd_idx == ID_IDX) begin
                rd_data = DATA_WIDTH'(ID_VALUE);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= s_axi.AWADDR;
            end
            if (w_hs) begin
                w_data_q <= s_axi.WDATA;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (commit && wr_ok && (wr_idx == IDX_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Commit only happens with BVALID low, so set and clear never collide.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            s_axi.BVALID <= 1'b0;
            s_axi.BRESP  <= 2'b00;
        end else if (commit) begin
            s_axi.BVALID <= 1'b1;
            s_axi.BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi.BVALID && s_axi.BREADY) begin
            s_axi.BVALID <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            s_axi.RVALID <= 1'b0;
            s_axi.RDATA  <= '0;
            s_axi.RRESP  <= 2'b00;
        end else if (ar_hs) begin
            s_axi.RVALID <= 1'b1;
            s_axi.RDATA  <= rd_data;
            s_axi.RRESP  <= rd_resp;
        end else if (s_axi.RVALID && s_axi.RREADY) begin
            s_axi.RVALID <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        if (g == NUM_REGS - 1) begin : g_id
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(ID_VALUE);
        end else begin : g_rw
            assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    end

endmodule
